mem_rd_arbiter: RTL and testbench
=================================

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_BEATS, default 4, giving the beats returned for a cache-line read (rd_type 3'b100).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
- aclk  in  1  clock; all state updates on the rising edge
- aresetn  in  1  synchronous active-low reset
- ic_rd_req  in  1  icache read request
- ic_rd_type  in  3  000 byte, 001 half, 010 word, 100 line
- ic_rd_addr  in  32  icache read start address
- ic_rd_rdy  out  1  icache request accepted this cycle when high with ic_rd_req
- ic_ret_valid  out  1  return beat for icache
- ic_ret_last  out  1  final icache return beat
- dc_rd_req  in  1  dcache read request
- dc_rd_type  in  3  encoding as ic_rd_type
- dc_rd_addr  in  32  dcache read start address
- dc_rd_rdy  out  1  dcache request accepted
- dc_ret_valid  out  1  return beat for dcache
- dc_ret_last  out  1  final dcache return beat
- ret_data  out  32  shared return data; qualified by ic_ret_valid/dc_ret_valid
- mem_rd_req  out  1  read request to AXI bridge
- mem_rd_type  out  3  forwarded type
- mem_rd_addr  out  32  forwarded address
- mem_rd_rdy  in  1  bridge accepts request
- mem_ret_valid  in  1  bridge return beat valid
- mem_ret_last  in  1  bridge final beat
- mem_ret_data  in  32  bridge return data
- proto_err  out  1  sticky; a return beat count did not match the expected count

Function
REQ-003 The FSM SHALL use three one-hot states: IDLE, REQ and RESP.
REQ-004 In IDLE, the block SHALL assert exactly one of ic_rd_rdy/dc_rd_rdy, for the granted requester, and only when that requester's rd_req is high; both SHALL be 0 in REQ and RESP.
REQ-005 On accept (rd_req & rd_rdy), the block SHALL register owner, type and addr, and go IDLE->REQ on the next edge, so mem_rd_req rises 1 cycle after accept.
REQ-006 In REQ, mem_rd_req SHALL be 1 and mem_rd_type/mem_rd_addr SHALL be stable from the registers; on mem_rd_req & mem_rd_rdy the FSM SHALL go REQ->RESP.
REQ-007 In RESP, the block SHALL route combinationally, with zero latency: owner_ret_valid = mem_ret_valid, owner_ret_last = mem_ret_valid & mem_ret_last, ret_data = mem_ret_data; the non-owner's ret_valid/ret_last SHALL be 0.
REQ-008 On mem_ret_valid & mem_ret_last in RESP, the FSM SHALL go RESP->IDLE; a new grant is possible the cycle after the last beat, giving one transaction outstanding at a time.
REQ-009 The 3-bit beat counter SHALL clear on accept and increment per mem_ret_valid in RESP.
REQ-010 At the last beat, if (counter+1) != expected (LINE_BEATS for type 100, else 1), proto_err SHALL set and stay set until reset; the transaction SHALL still complete normally.
REQ-011 mem_ret_valid outside RESP SHALL be ignored: no ret_valid is asserted and the FSM is unaffected.
REQ-012 Fixed priority (macro absent): dcache SHALL win when both request in IDLE.
REQ-013 Requester inputs SHALL be ignored outside IDLE; requesters hold req until accepted.
REQ-014 Outside RESP, ret_data SHALL be driven with mem_ret_data; it is don't-care when no ret_valid is high.

Reset
REQ-015 With aresetn low at an edge, the block SHALL enter IDLE, clear the owner, type, addr and counter registers, clear proto_err, and clear the round-robin pointer so dcache is preferred next.
REQ-016 Reset mid-transaction SHALL abandon the transaction: all outputs SHALL be 0 in the cycle after reset, and no further return beats SHALL be routed.

Configuration
REQ-017 With ARB_RR_EN defined, grant SHALL be round-robin: a 1-bit pointer names the last-served requester, and on simultaneous requests the other one wins; the pointer SHALL update on accept.
REQ-018 With ARB_RR_EN undefined, there SHALL be no pointer and the fixed-priority rule of REQ-012 SHALL apply.

Verification
REQ-019 icache-only request, ic_rd_addr=0x1C000000, type 100, mem_rd_rdy=1 at once, 4 return beats D0..D3 -> ic_rd_rdy=1 in the accept cycle; mem_rd_req=1 one cycle later; ic_ret_valid on 4 beats with ret_data=D0..D3; ic_ret_last only on D3; proto_err=0.
REQ-020 Simultaneous ic/dc requests twice in a row, with ARB_RR_EN undefined -> dc granted both times. With ARB_RR_EN defined -> dc first, then ic.
REQ-021 dcache word read 0x80001004, mem_rd_rdy held low 5 cycles -> mem_rd_req, mem_rd_addr and mem_rd_type stable for 6 cycles; 1 beat routed to dc_ret_valid with dc_ret_last=1; ic_ret_valid stays 0.
REQ-022 Line read returning only 2 beats with mem_ret_last on beat 2 -> proto_err=1 from the next cycle and stays 1; FSM returns to IDLE; next request serviced normally.
REQ-023 Reset asserted during RESP after beat 1, stray mem_ret_valid afterwards -> all outputs 0; stray beats ignored; next ic request granted in IDLE.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: arbitrates icache/dcache reads onto one memory read port, one transaction at a time.
// Define ARB_RR_EN for round-robin grant; otherwise dcache has fixed priority.
module mem_rd_arbiter #(
    parameter int LINE_BEATS = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] ret_data,
    output logic        mem_rd_req,
    output logic [2:0]  mem_rd_type,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_rdy,
    input  logic        mem_ret_valid,
    input  logic        mem_ret_last,
    input  logic [31:0] mem_ret_data,
    output logic        proto_err
);
    localparam logic [2:0] LINE_CNT = 3'(LINE_BEATS);
    typedef enum logic [2:0] {IDLE = 3'b001, REQ = 3'b010, RESP = 3'b100} state_t;
    state_t      state;
    logic        owner_dc;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [2:0]  cnt;
    logic        grant_dc;
    logic        in_resp;
    logic [2:0]  exp_beats;
`ifdef ARB_RR_EN
    logic        last_dc;
    assign grant_dc = dc_rd_req & (~ic_rd_req | ~last_dc);
`else
    assign grant_dc = dc_rd_req;
`endif
    assign in_resp   = state == RESP;
    assign exp_beats = (type_q == 3'b100) ? LINE_CNT : 3'd1;
    // Grant handshake, request forwarding and zero-latency return routing to the owner
    always_comb begin
        ic_rd_rdy    = (state == IDLE) & ic_rd_req & ~grant_dc;
        dc_rd_rdy    = (state == IDLE) & grant_dc;
        mem_rd_req   = state == REQ;
        mem_rd_type  = type_q;
        mem_rd_addr  = addr_q;
        ic_ret_valid = in_resp & ~owner_dc & mem_ret_valid;
        dc_ret_valid = in_resp & owner_dc & mem_ret_valid;
        ic_ret_last  = ic_ret_valid & mem_ret_last;
        dc_ret_last  = dc_ret_valid & mem_ret_last;
        ret_data     = mem_ret_data;
    end
    // Transaction FSM: capture on accept, hold request until taken, count beats and flag bad lengths
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            owner_dc  <= 1'b0;
            type_q    <= 3'd0;
            addr_q    <= 32'd0;
            cnt       <= 3'd0;
            proto_err <= 1'b0;
`ifdef ARB_RR_EN
            last_dc   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (ic_rd_rdy | dc_rd_rdy) begin
                    owner_dc <= grant_dc;
                    type_q   <= grant_dc ? dc_rd_type : ic_rd_type;
                    addr_q   <= grant_dc ? dc_rd_addr : ic_rd_addr;
                    cnt      <= 3'd0;
                    state    <= REQ;
`ifdef ARB_RR_EN
                    last_dc  <= grant_dc;
`endif
                end
                REQ: if (mem_rd_rdy) state <= RESP;
                RESP: if (mem_ret_valid) begin
                    cnt <= cnt + 3'd1;
                    if (mem_ret_last) begin
                        state <= IDLE;
                        if (cnt + 3'd1 != exp_beats) proto_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed self-checking bench for mem_rd_arbiter.
module tb_mem_rd_arbiter;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ic_rd_req, dc_rd_req;
    logic [2:0]  ic_rd_type, dc_rd_type;
    logic [31:0] ic_rd_addr, dc_rd_addr;
    logic        ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic        dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [31:0] ret_data;
    logic        mem_rd_req;
    logic [2:0]  mem_rd_type;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_rdy, mem_ret_valid, mem_ret_last;
    logic [31:0] mem_ret_data;
    logic        proto_err;
    int          checks = 0;
    int          failures = 0;
    logic        win_dc;

    mem_rd_arbiter #(.LINE_BEATS(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .ret_data(ret_data),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
        .mem_ret_data(mem_ret_data), .proto_err(proto_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ic_rdy"}, ic_rd_rdy, 0);
        chk({tag, "_dc_rdy"}, dc_rd_rdy, 0);
        chk({tag, "_ic_val"}, ic_ret_valid, 0);
        chk({tag, "_ic_last"}, ic_ret_last, 0);
        chk({tag, "_dc_val"}, dc_ret_valid, 0);
        chk({tag, "_dc_last"}, dc_ret_last, 0);
        chk({tag, "_mreq"}, mem_rd_req, 0);
        chk({tag, "_maddr"}, mem_rd_addr, 0);
        chk({tag, "_mtype"}, mem_rd_type, 0);
        chk({tag, "_perr"}, proto_err, 0);
    endtask

    task automatic run_txn(input logic dc, input logic [2:0] ty, input logic [31:0] ad,
                           input int stall, input int beats);
        @(negedge aclk);
        if (dc) begin
            dc_rd_req = 1; dc_rd_type = ty; dc_rd_addr = ad;
        end else begin
            ic_rd_req = 1; ic_rd_type = ty; ic_rd_addr = ad;
        end
        #1;
        chk("acc_ic_rdy", ic_rd_rdy, !dc);
        chk("acc_dc_rdy", dc_rd_rdy, dc);
        chk("acc_mreq", mem_rd_req, 0);
        @(negedge aclk);
        ic_rd_req = 0; dc_rd_req = 0;
        for (int i = 0; i <= stall; i++) begin
            mem_rd_rdy = (i == stall);
            #1;
            chk("req_mreq", mem_rd_req, 1);
            chk("req_addr", mem_rd_addr, ad);
            chk("req_type", mem_rd_type, ty);
            chk("req_rdy", ic_rd_rdy | dc_rd_rdy, 0);
            @(negedge aclk);
        end
        mem_rd_rdy = 0;
        for (int i = 0; i < beats; i++) begin
            mem_ret_valid = 1;
            mem_ret_last  = (i == beats - 1);
            mem_ret_data  = 32'hD000_0000 | 32'(i);
            #1;
            chk("ret_ic_val", ic_ret_valid, !dc);
            chk("ret_dc_val", dc_ret_valid, dc);
            chk("ret_ic_last", ic_ret_last, !dc && (i == beats - 1));
            chk("ret_dc_last", dc_ret_last, dc && (i == beats - 1));
            chk("ret_data", ret_data, 32'hD000_0000 | 32'(i));
            chk("ret_mreq", mem_rd_req, 0);
            @(negedge aclk);
        end
        mem_ret_valid = 0; mem_ret_last = 0;
    endtask

    initial begin
        aresetn = 0;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
        dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        mem_rd_rdy = 0; mem_ret_valid = 0; mem_ret_last = 0; mem_ret_data = 0;
        repeat (2) @(negedge aclk);
        #1;
        chk_quiet("rst");
        aresetn = 1;
        // icache line read, four beats
        run_txn(0, 3'b100, 32'h1C00_0000, 0, 4);
        #1;
        chk("line_perr", proto_err, 0);
        chk("line_idle", mem_rd_req, 0);
        // simultaneous requests twice in a row
        @(negedge aclk);
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_1000;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_2000;
        #1;
        chk("sim1_dc_rdy", dc_rd_rdy, 1);
        chk("sim1_ic_rdy", ic_rd_rdy, 0);
        @(negedge aclk);
        dc_rd_req = 0; mem_rd_rdy = 1;
        #1;
        chk("sim1_ic_held_rdy", ic_rd_rdy, 0);
        chk("sim1_addr", mem_rd_addr, 32'h0000_2000);
        @(negedge aclk);
        mem_rd_rdy = 0; mem_ret_valid = 1; mem_ret_last = 1; mem_ret_data = 32'h1234_5678;
        #1;
        chk("sim1_dc_val", dc_ret_valid, 1);
        chk("sim1_ic_val", ic_ret_valid, 0);
        @(negedge aclk);
        mem_ret_valid = 0; mem_ret_last = 0; dc_rd_req = 1;
`ifdef ARB_RR_EN
        win_dc = 0;
`else
        win_dc = 1;
`endif
        #1;
        chk("sim2_dc_rdy", dc_rd_rdy, win_dc);
        chk("sim2_ic_rdy", ic_rd_rdy, !win_dc);
        @(negedge aclk);
        if (win_dc) dc_rd_req = 0; else ic_rd_req = 0;
        mem_rd_rdy = 1;
        #1;
        chk("sim2_addr", mem_rd_addr, win_dc ? 32'h0000_2000 : 32'h0000_1000);
        @(negedge aclk);
        mem_rd_rdy = 0; mem_ret_valid = 1; mem_ret_last = 1;
        #1;
        chk("sim2_dc_val", dc_ret_valid, win_dc);
        chk("sim2_ic_val", ic_ret_valid, !win_dc);
        @(negedge aclk);
        mem_ret_valid = 0; mem_ret_last = 0; ic_rd_req = 0; dc_rd_req = 0;
        // dcache word read with five stall cycles
        run_txn(1, 3'b010, 32'h8000_1004, 5, 1);
        #1;
        chk("word_perr", proto_err, 0);
        // short line read sets sticky proto_err
        run_txn(0, 3'b100, 32'h1C00_0040, 0, 2);
        #1;
        chk("short_perr", proto_err, 1);
        chk("short_idle", mem_rd_req, 0);
        @(negedge aclk);
        #1;
        chk("short_perr_hold", proto_err, 1);
        run_txn(1, 3'b000, 32'h8000_0003, 1, 1);
        #1;
        chk("after_perr_sticky", proto_err, 1);
        // reset during RESP, then stray return beats
        @(negedge aclk);
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0080;
        @(negedge aclk);
        ic_rd_req = 0; mem_rd_rdy = 1;
        @(negedge aclk);
        mem_rd_rdy = 0; mem_ret_valid = 1; mem_ret_data = 32'hAAAA_0000;
        #1;
        chk("rr_beat1", ic_ret_valid, 1);
        @(negedge aclk);
        aresetn = 0;
        @(negedge aclk);
        aresetn = 1; mem_ret_last = 1;
        #1;
        chk_quiet("post_rst");
        @(negedge aclk);
        #1;
        chk_quiet("stray");
        mem_ret_valid = 0; mem_ret_last = 0;
        run_txn(0, 3'b000, 32'h1C00_0001, 0, 1);
        #1;
        chk("final_perr", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
